// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode command sequencer.
package sd_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_REQ,
      SEND_WAIT,
      SKIP_ECHO,
      POLL_R1,
      RESP,
      DONE
   } state_t;

   localparam logic [1:0] SD_START_BITS = 2'b01;
   localparam logic [6:0] CRC7_POLY     = 7'h09;
   localparam logic [7:0] FILLER_BYTE   = 8'hFF;
   localparam int         CMD_FRAME_LEN = 6;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0) over the 40-bit command head, MSB first.
module sd_crc7
   import sd_spi_pkg::*;
(
   input  logic [39:0] i_data,
   output logic [6:0]  o_crc
);

   logic [6:0] w_crc;
   logic       w_fb;

   always_comb begin
      w_crc = '0;
      w_fb  = 1'b0;
      for (int i = 39; i >= 0; i--) begin
         w_fb  = i_data[i] ^ w_crc[6];
         w_crc = {w_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
      end
   end

   assign o_crc = w_crc;

endmodule

// File: rtl/sd_spi_cmd_sequencer.sv
// Frames one SD SPI-mode command into the byte engine and collects R1 plus up
// to four trailing response bytes, with a bounded poll for R1.
module sd_spi_cmd_sequencer
   import sd_spi_pkg::*;
#(
   parameter int NCR_MAX = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        CmdStart,
   input  logic [5:0]  CmdIndex,
   input  logic [31:0] CmdArg,
   input  logic [2:0]  RespLen,
   output logic        Busy,
   output logic        CmdDone,
   output logic        CmdTimeout,
   output logic [7:0]  R1,
   output logic [31:0] RespData,
   output logic        SpiEnable,
   output logic [7:0]  SpiSendData,
   output logic        SpiSendReq,
   input  logic        SpiSendAck,
   input  logic [7:0]  SpiRecvData,
   input  logic        SpiRecvAdv,
   output logic        SpiRecvAck
);

   state_t      r_state;
   state_t      w_next;
   logic [39:0] r_cmd_bits;
   logic [6:0]  r_crc;
   logic [6:0]  w_crc;
   logic [2:0]  r_k;
   logic [2:0]  r_resp_len;
   logic [2:0]  r_resp_cnt;
   logic [7:0]  r_poll;
   logic [7:0]  r_r1;
   logic [31:0] r_resp_data;
   logic        r_timeout;
   logic        r_adv_hold;
   logic        w_byte_evt;
   logic        w_start;
   logic        w_k_inc;
   logic        w_poll_inc;
   logic        w_ld_r1;
   logic        w_set_to;
   logic        w_shift;
   logic [7:0]  w_send_byte;

   sd_crc7 u_crc7 (
      .i_data ({SD_START_BITS, CmdIndex, CmdArg}),
      .o_crc  (w_crc)
   );

   // r_adv_hold stays set until RecvAdv drops, so a long-held RecvAdv is acknowledged once.
   assign w_byte_evt = (r_state != IDLE) && SpiRecvAdv && !r_adv_hold;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_k_inc    = 1'b0;
      w_poll_inc = 1'b0;
      w_ld_r1    = 1'b0;
      w_set_to   = 1'b0;
      w_shift    = 1'b0;
      case (r_state)
         IDLE: begin
            if (CmdStart) begin
               w_start = 1'b1;
               w_next  = SEND_REQ;
            end
         end
         SEND_REQ: begin
            if (SpiSendAck) w_next = SEND_WAIT;
         end
         SEND_WAIT: begin
            if (!SpiSendAck) begin
               if (r_k == 3'(CMD_FRAME_LEN - 1)) begin
                  w_next = SKIP_ECHO;
               end else begin
                  w_k_inc = 1'b1;
                  w_next  = SEND_REQ;
               end
            end
         end
         SKIP_ECHO: begin
            if (w_byte_evt) w_next = POLL_R1;
         end
         POLL_R1: begin
            if (w_byte_evt) begin
               if (!SpiRecvData[7]) begin
                  w_ld_r1 = 1'b1;
                  w_next  = (r_resp_len != 3'd0) ? RESP : DONE;
               end else if (r_poll == 8'(NCR_MAX - 1)) begin
                  w_set_to = 1'b1;
                  w_next   = DONE;
               end else begin
                  w_poll_inc = 1'b1;
               end
            end
         end
         RESP: begin
            if (w_byte_evt) begin
               w_shift = 1'b1;
               if (r_resp_cnt == r_resp_len - 3'd1) w_next = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_k         <= '0;
         r_poll      <= '0;
         r_resp_cnt  <= '0;
         r_resp_len  <= '0;
         r_r1        <= '0;
         r_resp_data <= '0;
         r_timeout   <= 1'b0;
         r_adv_hold  <= 1'b0;
      end else begin
         r_adv_hold <= SpiRecvAdv && (w_byte_evt || r_adv_hold);
         if (w_start) begin
            r_k         <= '0;
            r_poll      <= '0;
            r_resp_cnt  <= '0;
            r_resp_len  <= (RespLen > 3'd4) ? 3'd4 : RespLen;
            r_r1        <= '0;
            r_resp_data <= '0;
            r_timeout   <= 1'b0;
         end
         if (w_k_inc)    r_k       <= r_k + 3'd1;
         if (w_poll_inc) r_poll    <= r_poll + 8'd1;
         if (w_ld_r1)    r_r1      <= SpiRecvData;
         if (w_set_to)   r_timeout <= 1'b1;
         if (w_shift) begin
            r_resp_data <= {r_resp_data[23:0], SpiRecvData};
            r_resp_cnt  <= r_resp_cnt + 3'd1;
         end
      end
   end

   // Frame head and CRC are captured once at start; only control state is reset.
   always_ff @(posedge Clk) begin
      if (w_start) begin
         r_cmd_bits <= {SD_START_BITS, CmdIndex, CmdArg};
         r_crc      <= w_crc;
      end
   end

   always_comb begin
      case (r_k)
         3'd0:    w_send_byte = r_cmd_bits[39:32];
         3'd1:    w_send_byte = r_cmd_bits[31:24];
         3'd2:    w_send_byte = r_cmd_bits[23:16];
         3'd3:    w_send_byte = r_cmd_bits[15:8];
         3'd4:    w_send_byte = r_cmd_bits[7:0];
         3'd5:    w_send_byte = {r_crc, 1'b1};
         default: w_send_byte = FILLER_BYTE;
      endcase
   end

   assign Busy        = (r_state != IDLE);
   assign CmdDone     = (r_state == DONE);
   assign SpiEnable   = (r_state != IDLE) && (r_state != DONE);
   assign SpiSendReq  = (r_state == SEND_REQ);
   assign SpiSendData = (r_state == SEND_REQ) ? w_send_byte : 8'h00;
   assign SpiRecvAck  = w_byte_evt;
   assign CmdTimeout  = r_timeout;
   assign R1          = r_r1;
   assign RespData    = r_resp_data;

endmodule

// File: tb/tb_sd_spi_cmd_sequencer.sv
// Directed bench for sd_spi_cmd_sequencer with a behavioural SPI byte-engine responder.
module tb_sd_spi_cmd_sequencer;
   import sd_spi_pkg::*;

   logic        Clk;
   logic        Rst_n;
   logic        CmdStart;
   logic [5:0]  CmdIndex;
   logic [31:0] CmdArg;
   logic [2:0]  RespLen;
   logic        Busy;
   logic        CmdDone;
   logic        CmdTimeout;
   logic [7:0]  R1;
   logic [31:0] RespData;
   logic        SpiEnable;
   logic [7:0]  SpiSendData;
   logic        SpiSendReq;
   logic        SpiSendAck;
   logic [7:0]  SpiRecvData;
   logic        SpiRecvAdv;
   logic        SpiRecvAck;

   sd_spi_cmd_sequencer #(.NCR_MAX(8)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .CmdStart    (CmdStart),
      .CmdIndex    (CmdIndex),
      .CmdArg      (CmdArg),
      .RespLen     (RespLen),
      .Busy        (Busy),
      .CmdDone     (CmdDone),
      .CmdTimeout  (CmdTimeout),
      .R1          (R1),
      .RespData    (RespData),
      .SpiEnable   (SpiEnable),
      .SpiSendData (SpiSendData),
      .SpiSendReq  (SpiSendReq),
      .SpiSendAck  (SpiSendAck),
      .SpiRecvData (SpiRecvData),
      .SpiRecvAdv  (SpiRecvAdv),
      .SpiRecvAck  (SpiRecvAck)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Engine configuration and reply table, written only by the main sequence.
   int         ack_hold = 1;
   int         adv_hold = 0;
   logic [7:0] rep [0:7];
   int         n_rep = 0;

   // Engine-side records, written only by the engine process.
   logic [7:0] sent_q [0:255];
   int         n_sent = 0;
   int         n_adv  = 0;

   // Monitor counters, written only by the monitor process.
   int   n_ack     = 0;
   int   n_ack_dbl = 0;
   int   n_done    = 0;
   logic ack_prev  = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   int base_sent, base_adv, base_ack, base_dbl, base_done;

   initial begin
      forever begin
         @(negedge Clk);
         if (SpiRecvAck) n_ack++;
         if (SpiRecvAck && ack_prev) n_ack_dbl++;
         ack_prev = SpiRecvAck;
         if (CmdDone) n_done++;
      end
   end

   // Byte engine: each slot loads a requested byte (or shifts filler), then offers one received byte.
   initial begin
      int e_st;
      int e_cnt;
      int e_slot;
      e_st = 0; e_cnt = 0; e_slot = 0;
      SpiSendAck = 1'b0; SpiRecvAdv = 1'b0; SpiRecvData = 8'h00;
      forever begin
         @(posedge Clk); #1;
         if (!Rst_n || !SpiEnable) begin
            e_st = 0; e_slot = 0;
            SpiSendAck = 1'b0; SpiRecvAdv = 1'b0;
         end else begin
            case (e_st)
               0: begin
                  if (SpiSendReq) begin
                     if (n_sent < 256) sent_q[n_sent] = SpiSendData;
                     n_sent++;
                     SpiSendAck = 1'b1;
                     e_cnt = ack_hold;
                     e_st = 1;
                  end else begin
                     e_cnt = 2;
                     e_st = 2;
                  end
               end
               1: begin
                  e_cnt--;
                  if (e_cnt <= 0) begin
                     SpiSendAck = 1'b0;
                     e_cnt = 2;
                     e_st = 2;
                  end
               end
               2: begin
                  e_cnt--;
                  if (e_cnt <= 0) begin
                     if (e_slot < CMD_FRAME_LEN || (e_slot - CMD_FRAME_LEN) >= n_rep)
                        SpiRecvData = FILLER_BYTE;
                     else
                        SpiRecvData = rep[e_slot - CMD_FRAME_LEN];
                     SpiRecvAdv = 1'b1;
                     n_adv++;
                     e_slot++;
                     e_cnt = adv_hold;
                     e_st = 3;
                  end
               end
               default: begin
                  if (adv_hold == 0) begin
                     if (ack_prev) begin
                        SpiRecvAdv = 1'b0;
                        e_st = 0;
                     end
                  end else begin
                     e_cnt--;
                     if (e_cnt <= 0) begin
                        SpiRecvAdv = 1'b0;
                        e_st = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic snap();
      base_sent = n_sent;
      base_adv  = n_adv;
      base_ack  = n_ack;
      base_dbl  = n_ack_dbl;
      base_done = n_done;
   endtask

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len);
      @(posedge Clk); #1;
      CmdIndex = idx; CmdArg = arg; RespLen = len; CmdStart = 1'b1;
      @(posedge Clk); #1;
      CmdStart = 1'b0; CmdIndex = 6'h3F; CmdArg = 32'hDEADBEEF; RespLen = 3'd7;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if (CmdDone) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [47:0] frame48(input int b);
      return {sent_q[b], sent_q[b+1], sent_q[b+2], sent_q[b+3], sent_q[b+4], sent_q[b+5]};
   endfunction

   initial begin
      bit ok;
      Rst_n = 1'b1; CmdStart = 1'b0; CmdIndex = '0; CmdArg = '0; RespLen = '0;
      #2 Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rst_busy",  Busy, 0);
      chk("rst_done",  CmdDone, 0);
      chk("rst_en",    SpiEnable, 0);
      chk("rst_req",   SpiSendReq, 0);
      chk("rst_sdata", SpiSendData, 0);
      chk("rst_r1",    R1, 0);
      chk("rst_resp",  RespData, 0);
      chk("rst_to",    CmdTimeout, 0);
      chk("rst_rack",  SpiRecvAck, 0);
      @(posedge Clk); #1 Rst_n = 1'b1;

      // CMD0: FF, FF, 01 after the echo
      rep[0] = 8'hFF; rep[1] = 8'hFF; rep[2] = 8'h01; n_rep = 3;
      snap();
      start_cmd(6'd0, 32'h0, 3'd0);
      wait_done(400, ok);
      chk("cmd0_done_seen", ok, 1);
      chk("cmd0_frame", frame48(base_sent), 48'h40_00_00_00_00_95);
      chk("cmd0_nsent", n_sent - base_sent, 6);
      chk("cmd0_r1", R1, 8'h01);
      chk("cmd0_timeout", CmdTimeout, 0);
      chk("cmd0_polls", n_adv - base_adv - 6, 3);
      chk("cmd0_busy_at_done", Busy, 1);
      chk("cmd0_en_at_done", SpiEnable, 0);
      @(negedge Clk);
      chk("cmd0_busy_fall", Busy, 0);
      chk("cmd0_done_pulse", CmdDone, 0);

      // CMD8 with four trailing bytes
      rep[0] = 8'h01; rep[1] = 8'h00; rep[2] = 8'h00; rep[3] = 8'h01; rep[4] = 8'hAA; n_rep = 5;
      snap();
      start_cmd(6'd8, 32'h0000_01AA, 3'd4);
      wait_done(400, ok);
      chk("cmd8_done_seen", ok, 1);
      chk("cmd8_frame", frame48(base_sent), 48'h48_00_00_01_AA_87);
      chk("cmd8_r1", R1, 8'h01);
      chk("cmd8_resp", RespData, 32'h0000_01AA);
      chk("cmd8_timeout", CmdTimeout, 0);

      // CMD17 with no R1: timeout after exactly NCR_MAX polls
      n_rep = 0;
      snap();
      start_cmd(6'd17, 32'h0000_1234, 3'd0);
      wait_done(600, ok);
      chk("cmd17_done_seen", ok, 1);
      chk("cmd17_head", frame48(base_sent) >> 8, 40'h51_00_00_12_34);
      chk("cmd17_endbit", sent_q[base_sent + 5][0], 1);
      chk("cmd17_timeout", CmdTimeout, 1);
      chk("cmd17_r1", R1, 8'h00);
      chk("cmd17_resp_cleared", RespData, 0);
      chk("cmd17_polls", n_adv - base_adv - 6, 8);

      // Second CmdStart while busy is ignored
      rep[0] = 8'h01; n_rep = 1;
      snap();
      start_cmd(6'd8, 32'h0000_01AA, 3'd0);
      repeat (3) @(posedge Clk);
      #1 CmdIndex = 6'd17; CmdArg = 32'h1111_2222; CmdStart = 1'b1;
      @(posedge Clk); #1 CmdStart = 1'b0;
      wait_done(400, ok);
      chk("busy_done_seen", ok, 1);
      chk("busy_frame", frame48(base_sent), 48'h48_00_00_01_AA_87);
      repeat (20) @(negedge Clk);
      chk("busy_one_done", n_done - base_done, 1);
      chk("busy_nsent", n_sent - base_sent, 6);
      chk("busy_idle", Busy, 0);

      // Reset while waiting for B3 to be loaded
      ack_hold = 3;
      rep[0] = 8'h01; n_rep = 1;
      snap();
      start_cmd(6'd8, 32'h0000_01AA, 3'd0);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         if ((n_sent - base_sent) == 4 && !SpiSendReq && Busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_mid_reached", ok, 1);
      Rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {SpiEnable, SpiSendReq, Busy}, 3'b000);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      repeat (5) @(negedge Clk);
      chk("rst_mid_no_done", n_done - base_done, 0);
      ack_hold = 1;
      snap();
      start_cmd(6'd0, 32'h0, 3'd0);
      wait_done(400, ok);
      chk("rst_fresh_done_seen", ok, 1);
      chk("rst_fresh_frame", frame48(base_sent), 48'h40_00_00_00_00_95);
      chk("rst_fresh_r1", R1, 8'h01);

      // Slow engine: long SendAck and RecvAdv levels
      ack_hold = 5; adv_hold = 3;
      rep[0] = 8'h01; n_rep = 1;
      snap();
      start_cmd(6'd0, 32'h0, 3'd0);
      wait_done(600, ok);
      chk("slow_done_seen", ok, 1);
      chk("slow_nsent", n_sent - base_sent, 6);
      chk("slow_frame", frame48(base_sent), 48'h40_00_00_00_00_95);
      chk("slow_adv_count", n_adv - base_adv, 7);
      chk("slow_ack_count", n_ack - base_ack, n_adv - base_adv);
      chk("slow_ack_width", n_ack_dbl - base_dbl, 0);
      chk("slow_r1", R1, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
